// File: rtl/bf16_feeder_pkg.sv
// Shared types and constants for the bf16 MAC operand feeder.
// Optional statistics counters are enabled with `define BF16_FEEDER_STATS_EN.
package bf16_feeder_pkg;

    localparam int unsigned BF16_W = 16;
    localparam int unsigned STAT_W = 16;

    typedef logic [BF16_W-1:0] bf16_t;

    typedef struct packed {
        logic  last;
        bf16_t a;
        bf16_t b;
    } pair_t;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } feeder_state_t;

    localparam bf16_t BF16_ZERO = 16'h0000;
    localparam logic  CNTL_LOAD = 1'b1;
    localparam logic  CNTL_ACC  = 1'b0;

    // Saturating increment for the statistics counters
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/bf16_pair_fifo.sv
// Synchronous FIFO of operand pairs; a push is refused whenever the FIFO is full,
// even if a pop happens in the same cycle.
module bf16_pair_fifo
    import bf16_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  pair_t                      push_data,
    input  logic                       pop,
    output pair_t                      head_c,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    pair_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [CW-1:0] count_nxt;

    always_comb begin
        do_push   = push && !full;
        do_pop    = pop && !empty;
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    assign head_c = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/bf16_mac_feeder.sv
// Operand sequencer for the bf16 MAC: issues buffered pairs, marks vector starts,
// drains the MAC pipeline and holds the result. Define BF16_FEEDER_STATS_EN for counters.
module bf16_mac_feeder
    import bf16_feeder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAC_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_last,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    output logic        mac_cntl,
    input  logic [15:0] mac_out,
    output logic        res_valid,
    output logic [15:0] res_data,
    input  logic        res_ready
`ifdef BF16_FEEDER_STATS_EN
    ,
    output logic [15:0] vec_count,
    output logic [15:0] pair_count
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned DW = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

    feeder_state_t state;
    logic          first_flag;
    logic [DW-1:0] drain_cnt;

    pair_t         push_data;
    pair_t         head_c;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop_c;

    always_comb begin
        push_data      = '0;
        push_data.last = in_last;
        push_data.a    = in_a;
        push_data.b    = in_b;
        pop_c          = (state == ISSUE) && !fifo_empty;
    end

    assign in_ready = !fifo_full;

    bf16_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (push_data),
        .pop       (pop_c),
        .head_c    (head_c),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Sequencer: bubbles (+0.0, accumulate) are the default on every cycle nothing issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ISSUE;
            first_flag <= 1'b1;
            drain_cnt  <= '0;
            mac_a      <= BF16_ZERO;
            mac_b      <= BF16_ZERO;
            mac_cntl   <= CNTL_ACC;
            res_valid  <= 1'b0;
            res_data   <= BF16_ZERO;
        end else begin
            mac_a    <= BF16_ZERO;
            mac_b    <= BF16_ZERO;
            mac_cntl <= CNTL_ACC;
            case (state)
                ISSUE: begin
                    if (pop_c) begin
                        mac_a      <= head_c.a;
                        mac_b      <= head_c.b;
                        mac_cntl   <= first_flag ? CNTL_LOAD : CNTL_ACC;
                        first_flag <= head_c.last;
                        if (head_c.last) begin
                            state     <= DRAIN;
                            drain_cnt <= DW'(MAC_LAT);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        res_data  <= mac_out;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end

`ifdef BF16_FEEDER_STATS_EN
    // Saturating vector and issued-pair counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_count  <= '0;
            pair_count <= '0;
        end else begin
            if (res_valid && res_ready) begin
                vec_count <= sat_inc(vec_count);
            end
            if (pop_c) begin
                pair_count <= sat_inc(pair_count);
            end
        end
    end
`endif

    a_full_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_full == (fifo_count == CW'(DEPTH)));

endmodule

// File: tb/tb_bf16_mac_feeder.sv
// Randomized self-checking bench for bf16_mac_feeder with a behavioural bf16 MAC.
module tb_bf16_mac_feeder;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAC_LAT = 1;

    typedef struct {
        logic        cntl;
        logic        last;
        logic [15:0] a;
        logic [15:0] b;
    } iss_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_last = 1'b0;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic        mac_cntl;
    logic [15:0] mac_out = 16'h0000;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_ready = 1'b0;
`ifdef BF16_FEEDER_STATS_EN
    logic [15:0] vec_count;
    logic [15:0] pair_count;
    logic [15:0] vc0, pc0;
`endif

    bf16_mac_feeder #(.DEPTH(DEPTH), .MAC_LAT(MAC_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_cntl  (mac_cntl),
        .mac_out   (mac_out),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready)
`ifdef BF16_FEEDER_STATS_EN
        ,
        .vec_count (vec_count),
        .pair_count(pair_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // bf16 <-> real helpers (normals only; zero exponent flushes to zero)
    function automatic real bf2r(input logic [15:0] h);
        logic [63:0] d;
        if (h[14:7] == 8'd0) return 0.0;
        d = {h[15], 11'(h[14:7]) + 11'd896, h[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] d;
        int          e;
        logic [7:0]  m;
        logic [44:0] rest;
        logic [44:0] half;
        d    = $realtobits(r);
        half = {1'b1, 44'd0};
        if (d[62:0] == 63'd0) return {d[63], 15'd0};
        e    = int'(d[62:52]) - 1023 + 127;
        m    = {1'b0, d[51:45]};
        rest = d[44:0];
        if (rest > half || (rest == half && m[0])) m = m + 8'd1;
        if (m[7]) begin
            m = 8'd0;
            e = e + 1;
        end
        if (e <= 0) return {d[63], 15'd0};
        if (e >= 255) return {d[63], 8'hFF, 7'd0};
        return {d[63], 8'(e), m[6:0]};
    endfunction

    function automatic logic [15:0] rnd_bf();
        logic [7:0] e;
        e = 8'($urandom_range(120, 134));
        return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
    endfunction

    // Behavioural MAC: one edge of latency, single rounding per step
    real mac_p;
    always @(posedge clk) begin
        mac_p = bf2r(mac_a) * bf2r(mac_b);
        mac_out <= r2bf(mac_cntl ? mac_p : bf2r(mac_out) + mac_p);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: what should be issued and which results should appear
    iss_t        exp_q[$];
    logic [15:0] res_q[$];
    int          issue_cyc_q[$];
    logic        tb_first = 1'b1;
    logic [15:0] tb_acc = '0;
    logic        stall_res = 1'b0;
    logic        rnd_ready = 1'b0;
    logic [15:0] last_res = '0;

    // Monitor: issue stream, bubbles, capture latency and results
    iss_t        mon_e;
    logic [33:0] mon_exp;
    logic [16:0] mon_res_exp;
    logic        res_valid_prev = 1'b0;
    int          last_issue_cyc = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mac_a == 16'h0 || mac_b == 16'h0) begin
                check("bubble", 64'({mac_cntl, mac_a, mac_b}), 64'd0);
            end else begin
                mon_exp = '0;
                if (exp_q.size() != 0) begin
                    mon_e   = exp_q.pop_front();
                    mon_exp = {1'b1, mon_e.cntl, mon_e.a, mon_e.b};
                    if (mon_e.last) last_issue_cyc = cyc;
                end
                check("issue", 64'({1'b1, mac_cntl, mac_a, mac_b}), 64'(mon_exp));
                issue_cyc_q.push_back(cyc);
            end
            if (res_valid && !res_valid_prev) begin
                check("latency", 64'(cyc - last_issue_cyc), 64'(MAC_LAT + 1));
            end
            if (res_valid && res_ready) begin
                mon_res_exp = 17'h1_0000;
                if (res_q.size() != 0) mon_res_exp = {1'b0, res_q.pop_front()};
                check("res_data", 64'({1'b0, res_data}), 64'(mon_res_exp));
                last_res = res_data;
            end
            res_valid_prev = res_valid;
        end
    end

    // Result consumer
    initial begin
        forever begin
            @(posedge clk);
            #2;
            res_ready = !stall_res && (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
        int  guard = 0;
        real p;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("push_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back('{cntl: tb_first, last: last, a: a, b: b});
        p      = bf2r(a) * bf2r(b);
        tb_acc = r2bf(tb_first ? p : bf2r(tb_acc) + p);
        if (last) res_q.push_back(tb_acc);
        tb_first = last;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        idle(1);
        while ((exp_q.size() != 0 || res_q.size() != 0) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("drain_timeout", 64'(exp_q.size() + res_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          len;

        // Reset held across edges
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_mac", 64'({mac_cntl, mac_a, mac_b}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0*1.0 + 0.5*0.5
        push_pair(16'h3F80, 16'h3F80, 1'b0);
        push_pair(16'h3F00, 16'h3F00, 1'b1);
        wait_idle();
        check("v1_res", 64'(last_res), 64'h3FA0);

        // 1.25 + 0.5*(-0.1), gap-free then with 3-cycle gaps
        push_pair(16'h3F80, 16'h3F80, 1'b0);
        push_pair(16'h3F00, 16'h3F00, 1'b0);
        push_pair(16'hBDCD, 16'h3F00, 1'b1);
        wait_idle();
        check("v2_res", 64'(last_res), 64'h3F9A);
        push_pair(16'h3F80, 16'h3F80, 1'b0);
        idle(3);
        push_pair(16'h3F00, 16'h3F00, 1'b0);
        idle(3);
        push_pair(16'hBDCD, 16'h3F00, 1'b1);
        wait_idle();
        check("v2_gap_res", 64'(last_res), 64'h3F9A);

        // Fill the FIFO while the result is held, then release
        stall_res = 1'b1;
        push_pair(rnd_bf(), rnd_bf(), 1'b0);
        push_pair(rnd_bf(), rnd_bf(), 1'b1);
        idle(4);
        for (int i = 0; i < DEPTH; i++) push_pair(rnd_bf(), rnd_bf(), i == DEPTH - 1);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 16'h4040;
        in_b     = 16'h4040;
        in_last  = 1'b1;
        check("full_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("full_in_ready2", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        issue_cyc_q.delete();
        stall_res = 1'b0;
        wait_idle();
        check("b2b_count", 64'(issue_cyc_q.size()), 64'(DEPTH));
        for (int i = 1; i < issue_cyc_q.size(); i++) begin
            check("b2b_gap", 64'(issue_cyc_q[i] - issue_cyc_q[i-1]), 64'd1);
        end

        // Single-element vector
`ifdef BF16_FEEDER_STATS_EN
        vc0 = vec_count;
        pc0 = pair_count;
`endif
        push_pair(16'h4000, 16'h3F80, 1'b1);
        wait_idle();
        check("single_res", 64'(last_res), 64'h4000);
`ifdef BF16_FEEDER_STATS_EN
        check("vec_count_inc", 64'(vec_count), 64'(vc0 + 16'd1));
        check("pair_count_inc", 64'(pair_count), 64'(pc0 + 16'd1));
`endif

        // Asynchronous reset in the middle of a vector
        ra = rnd_bf();
        rb = rnd_bf();
        push_pair(ra, rb, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("pre_rst_mac_a", 64'(mac_a), 64'(ra));
        rst_n = 1'b0;
        #1;
        check("arst_mac", 64'({mac_cntl, mac_a, mac_b}), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_res_valid", 64'(res_valid), 64'd0);
`ifdef BF16_FEEDER_STATS_EN
        check("arst_vec_count", 64'(vec_count), 64'd0);
        check("arst_pair_count", 64'(pair_count), 64'd0);
`endif
        exp_q.delete();
        res_q.delete();
        tb_first = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized vectors with random gaps and random result back-pressure
        rnd_ready = 1'b1;
        for (int v = 0; v < 25; v++) begin
            len = int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++) begin
                push_pair(rnd_bf(), rnd_bf(), k == len - 1);
                if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
            end
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
